// File: rtl/ntt_agu_param.sv
// ============================================================================
//  Module   : ntt_agu_param
//  Brief    : Radix-2^R NTT address generator with run control and backpressure
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_agu_param #(
    parameter int LOGN = 8,
    parameter int R    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          mode_i,
    input  logic                          out_ready_i,
    output logic                          busy_o,
    output logic                          out_valid_o,
    output logic [(LOGN << R)-1:0]        addr_o,
    output logic [LOGN-1:0]               tw_idx_o,
    output logic [$clog2(LOGN / R):0]     stage_o,
    output logic                          last_o,
    output logic                          done_o
);

    localparam int STAGES = LOGN / R;
    localparam int LANES  = 1 << R;
    localparam int SW     = $clog2(STAGES) + 1;
    localparam int GW     = (LOGN > R) ? LOGN - R : 1;
    localparam int GMAX   = (1 << (LOGN - R)) - 1;

    generate
        if (LOGN % R != 0) begin : g_param_check
            $error("ntt_agu_param: LOGN must be a multiple of R");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic [SW-1:0]             l_q, l_d;
    logic [GW-1:0]             g_q, g_d;
    logic                      valid_q, valid_d;
    logic [LANES*LOGN-1:0]     addr_q, addr_d;
    logic [LOGN-1:0]           tw_q, tw_d;
    logic [SW-1:0]             stage_q, stage_d;
    logic                      last_q, last_d;
    logic                      done_q, done_d;

    int                        i_bits;
    logic [LOGN-1:0]           g_ext, i_val, j_val, full_rev, rev, base;
    logic [LANES*LOGN-1:0]     lane_addr;
    logic                      load, g_last, final_grp;

    // Group counter g packs j above i: g = j * 2^i_bits + i, so one counter
    // wrapping at 2^(LOGN-R) walks i fastest and j slowest within a stage.
    always_comb begin
        i_bits    = LOGN - R * (int'(l_q) + 1);
        g_ext     = LOGN'(g_q);
        i_val     = g_ext & LOGN'((1 << i_bits) - 1);
        j_val     = g_ext >> i_bits;
        full_rev  = '0;
        for (int d = 0; d < STAGES; d++) begin
            full_rev[(STAGES-1-d)*R +: R] = j_val[d*R +: R];
        end
        rev       = full_rev >> (R * (STAGES - int'(l_q)));
        base      = rev << (LOGN - R * int'(l_q));
        lane_addr = '0;
        for (int m = 0; m < LANES; m++) begin
            lane_addr[m*LOGN +: LOGN] = base + (LOGN'(m) << i_bits) + i_val;
        end
    end

    assign load      = (state_q == S_RUN) && (!valid_q || out_ready_i);
    assign g_last    = (g_q == GW'(GMAX));
    assign final_grp = g_last && (l_q == (mode_q ? SW'(0) : SW'(STAGES - 1)));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        l_d     = l_q;
        g_d     = g_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        tw_d    = tw_q;
        stage_d = stage_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    mode_d  = mode_i;
                    l_d     = mode_i ? SW'(STAGES - 1) : '0;
                    g_d     = '0;
                end
            end
            S_RUN: begin
                if (load) begin
                    valid_d = 1'b1;
                    addr_d  = lane_addr;
                    tw_d    = rev;
                    stage_d = l_q;
                    last_d  = final_grp;
                    if (final_grp) begin
                        state_d = S_DRAIN;
                    end else if (g_last) begin
                        g_d = '0;
                        l_d = mode_q ? l_q - SW'(1) : l_q + SW'(1);
                    end else begin
                        g_d = g_q + GW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (valid_q && out_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            l_q     <= '0;
            g_q     <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            tw_q    <= '0;
            stage_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            l_q     <= l_d;
            g_q     <= g_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            tw_q    <= tw_d;
            stage_q <= stage_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // busy covers the done cycle so a chained start keeps it continuously high
    assign busy_o      = (state_q != S_IDLE) || done_q;
    assign out_valid_o = valid_q;
    assign addr_o      = addr_q;
    assign tw_idx_o    = tw_q;
    assign stage_o     = stage_q;
    assign last_o      = last_q;
    assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ntt_agu_param.sv
// ============================================================================
//  Module   : tb_ntt_agu_param
//  Brief    : Scoreboard bench for ntt_agu_param (LOGN=8, R=2)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ntt_agu_param;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        mode_i;
    logic        out_ready_i;
    logic        busy_o;
    logic        out_valid_o;
    logic [31:0] addr_o;
    logic [7:0]  tw_idx_o;
    logic [2:0]  stage_o;
    logic        last_o;
    logic        done_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  tw;
        logic [2:0]  stage;
        logic        last;
    } grp_t;

    grp_t sb_q[$];
    int   n_cmp;
    int   n_err;

    ntt_agu_param #(.LOGN(8), .R(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .addr_o      (addr_o),
        .tw_idx_o    (tw_idx_o),
        .stage_o     (stage_o),
        .last_o      (last_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: stage order by mode, j outer, i inner, digit reversal by division
    task automatic push_run(input bit mode);
        grp_t g;
        for (int s = 0; s < 4; s++) begin
            int l;
            int ni;
            int nj;
            l  = mode ? 3 - s : s;
            ni = 1 << (8 - 2 * (l + 1));
            nj = 1 << (2 * l);
            for (int j = 0; j < nj; j++) begin
                for (int i = 0; i < ni; i++) begin
                    int rev;
                    int t;
                    rev = 0;
                    t   = j;
                    for (int d = 0; d < l; d++) begin
                        rev = rev * 4 + (t % 4);
                        t   = t / 4;
                    end
                    for (int m = 0; m < 4; m++) begin
                        int a;
                        a = rev * (1 << (8 - 2 * l)) + m * ni + i;
                        g.addr[m*8 +: 8] = 8'(a);
                    end
                    g.tw    = 8'(rev);
                    g.stage = 3'(l);
                    g.last  = (s == 3) && (j == nj - 1) && (i == ni - 1);
                    sb_q.push_back(g);
                end
            end
        end
    endtask

    // pat: 0 always ready, 1 random ready, 2 three-cycle stall at group 100
    task automatic run_sb(input bit mode, input int pat, input bit chain, input bit poke);
        int   cyc;
        int   acc;
        int   total;
        int   stall_left;
        bit   stall_done;
        bit   expect_done;
        bit   chain_left;
        bit   check_idle;
        bit   started2;
        bit   prev_stall;
        bit   rdy;
        grp_t held;
        grp_t e;
        grp_t obs;
        push_run(mode);
        total = chain ? 512 : 256;
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = mode;
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = ~mode;
        cyc = 0; acc = 0; stall_left = 0; stall_done = 0; expect_done = 0;
        chain_left = chain; check_idle = 0; started2 = 0; prev_stall = 0;
        held = '0;
        forever begin
            if (cyc >= 3000) begin
                n_cmp++; n_err++;
                $display("FAIL timeout: accepted %0d groups, required %0d", acc, total);
                break;
            end
            if (started2) begin
                started2 = 0;
                start_i  = 1'b0;
                n_cmp++;
                if (busy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_chain: got %b required 1", busy_o);
                end
            end
            if (check_idle) begin
                n_cmp++;
                if ({busy_o, out_valid_o, done_o} !== 3'b000) begin
                    n_err++;
                    $display("FAIL idle_after_done: busy/valid/done got %b%b%b required 000", busy_o, out_valid_o, done_o);
                end
                break;
            end
            if (expect_done) begin
                expect_done = 0;
                n_cmp++;
                if ({done_o, busy_o} !== 2'b11) begin
                    n_err++;
                    $display("FAIL done_pulse: done/busy got %b%b required 11", done_o, busy_o);
                end
                if (chain_left) begin
                    chain_left = 0;
                    push_run(~mode);
                    start_i  = 1'b1;
                    mode_i   = ~mode;
                    started2 = 1;
                end else begin
                    check_idle = 1;
                end
            end else if (done_o) begin
                n_cmp++; n_err++;
                $display("FAIL spurious_done: done_o got 1 required 0 at group %0d", acc);
            end
            if (poke) begin
                start_i = (cyc >= 10 && cyc < 13) || cyc == 120;
                mode_i  = 1'b1;
            end
            case (pat)
                1: rdy = 1'($urandom_range(0, 1));
                2: begin
                    if (acc == 100 && !stall_done) begin
                        stall_left = 3;
                        stall_done = 1;
                    end
                    if (stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = 1'b1;
            endcase
            obs = '{addr: addr_o, tw: tw_idx_o, stage: stage_o, last: last_o};
            if (prev_stall) begin
                n_cmp++;
                if (out_valid_o !== 1'b1 || obs !== held) begin
                    n_err++;
                    $display("FAIL frozen: valid %b group %h required valid 1 group %h", out_valid_o, obs, held);
                end
            end
            prev_stall = 0;
            if (out_valid_o === 1'b1) begin
                if (!rdy) begin
                    prev_stall = 1;
                    held = obs;
                end else begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sb_empty: extra group %h at index %0d", obs, acc);
                    end else begin
                        e = sb_q.pop_front();
                        n_cmp++;
                        if (obs !== e) begin
                            n_err++;
                            $display("FAIL group[%0d]: got addr %h tw %0d st %0d last %b required addr %h tw %0d st %0d last %b", acc, obs.addr, obs.tw, obs.stage, obs.last, e.addr, e.tw, e.stage, e.last);
                        end
                        if (e.last) expect_done = 1;
                    end
                    if (acc < 256 && !mode && (acc == 0 || acc == 1 || acc == 80 || acc == 193)) begin
                        logic [31:0] k;
                        logic [7:0]  kt;
                        case (acc)
                            0:       begin k = 32'hC0804000; kt = 8'd0;  end
                            1:       begin k = 32'hC1814101; kt = 8'd0;  end
                            80:      begin k = 32'h70605040; kt = 8'd1;  end
                            default: begin k = 32'h43424140; kt = 8'd16; end
                        endcase
                        n_cmp++;
                        if (addr_o !== k || tw_idx_o !== kt) begin
                            n_err++;
                            $display("FAIL fwd_vector[%0d]: got %h tw %0d required %h tw %0d", acc, addr_o, tw_idx_o, k, kt);
                        end
                    end
                    if (acc < 256 && mode && (acc == 0 || acc == 255)) begin
                        logic [31:0] k;
                        logic [2:0]  ks;
                        k  = (acc == 0) ? 32'h03020100 : 32'hFFBF7F3F;
                        ks = (acc == 0) ? 3'd3 : 3'd0;
                        n_cmp++;
                        if (addr_o !== k || stage_o !== ks) begin
                            n_err++;
                            $display("FAIL rev_vector[%0d]: got %h st %0d required %h st %0d", acc, addr_o, stage_o, k, ks);
                        end
                    end
                    acc++;
                end
            end
            out_ready_i = rdy;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (acc != total || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL group_count: got %0d left %0d required %0d left 0", acc, sb_q.size(), total);
        end
        sb_q.delete();
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy_o, out_valid_o, addr_o, tw_idx_o, stage_o, last_o, done_o} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy %b valid %b addr %h tw %h st %h last %b done %b required all 0", busy_o, out_valid_o, addr_o, tw_idx_o, stage_o, last_o, done_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_forward;        run_sb(1'b0, 0, 1'b0, 1'b0); endtask
    task automatic test_reverse;        run_sb(1'b1, 0, 1'b0, 1'b0); endtask
    task automatic test_backpressure;   run_sb(1'b0, 2, 1'b0, 1'b0); endtask
    task automatic test_random_ready;   run_sb(1'b1, 1, 1'b0, 1'b0); endtask
    task automatic test_start_busy;     run_sb(1'b0, 1, 1'b0, 1'b1); endtask
    task automatic test_back_to_back;   run_sb(1'b0, 0, 1'b1, 1'b0); endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy_o, out_valid_o, addr_o, tw_idx_o, stage_o, last_o, done_o} !== '0) begin
            n_err++;
            $display("FAIL reset_midrun: got busy %b valid %b addr %h tw %h st %h done %b required all 0", busy_o, out_valid_o, addr_o, tw_idx_o, stage_o, done_o);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_o, out_valid_o, done_o} !== 3'b000) begin
                n_err++;
                $display("FAIL abort_quiet: busy/valid/done got %b%b%b required 000", busy_o, out_valid_o, done_o);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_forward();
        test_reverse();
        test_backpressure();
        test_random_ready();
        test_start_busy();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
